dice_roll_ctrl: RTL
===================

Name: dice_roll_ctrl

Overview:
- Sequences the dice-roll datapath and shares it between the seven debounced die buttons and the I2C slave application interface.
- Owns the BCD result counter (digit10/digit1), the roll/display state machine and the display timeout.
- Exposes a small register map to the I2C slave, so a host can start rolls, read results and tune timing.
- Sits between the debouncers / i2c_slave and the seven-segment mux/decoder.

Parameters:
TIMEOUT_DEFAULT, 8'd255, reset value of the TIMEOUT register (display time in ticks)
ROLL_LEN_DEFAULT, 8'd16, reset value of the ROLL_LEN register (I2C roll duration in ticks)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tick  input  1  one-cycle prescaler pulse (32 Hz)
btn  input  7  debounced level buttons [0]=d4 [1]=d6 [2]=d8 [3]=d10 [4]=d12 [5]=d20 [6]=d100
i2c_wen  input  1  one-cycle write strobe from i2c_slave
i2c_addr  input  8  register address from i2c_slave
i2c_wdata  input  8  write data
i2c_rdata_used  input  1  one-cycle pulse: current i2c_rdata consumed by master
i2c_rdata  output  8  read data, combinational from i2c_addr
digit10  output  4  BCD tens digit
digit1  output  4  BCD units digit
display_en  output  1  high while the result is to be shown
busy  output  1  high in BTN_ROLL or I2C_ROLL

Behaviour:
- Single clock domain, clocked on posedge clk. rst clears asynchronously to:
  - state IDLE; digit10=0, digit1=1; display_en=0; busy=0
  - die=0, src=0, collision=0
  - TIMEOUT=TIMEOUT_DEFAULT, ROLL_LEN=ROLL_LEN_DEFAULT; tick counter 0
- Die ranges (die code to min..max, shown as BCD):
  - 0: 1..4; 1: 1..6; 2: 1..8; 3: 1..10; 4: 1..12; 5: 1..20
  - 6: 00..99 (percentile)
  - code 7 is invalid.
- Rolling: each clk while busy, the BCD value decrements by one (borrow from digit1 0 to 9 with digit10-1). When the value equals the die min, the next value is the die max.
- On entry to a roll, the value loads the die max on the first busy cycle.
- States:
  - IDLE/SHOW and any btn set: go to BTN_ROLL. The lowest set index is latched as die; src=0.
  - IDLE/SHOW, no btn, and I2C start accepted: go to I2C_ROLL. die=CTRL[2:0]; src=1; tick counter=ROLL_LEN.
  - BTN_ROLL: keep rolling while btn[die] is held. Other buttons are ignored. When btn[die] is released, go to SHOW.
  - I2C_ROLL: on each tick, the counter decrements. On a tick with counter<=1 (ROLL_LEN=0 ends at first tick), go to SHOW.
  - SHOW: on entry, the counter loads TIMEOUT and display_en=1. The counter decrements per tick. On a tick with counter<=1, go to IDLE and display_en=0. The value freezes in SHOW/IDLE.
- display_en=0 during BTN_ROLL/I2C_ROLL and IDLE.
- A button press in SHOW aborts the display and starts a new roll. An I2C start in SHOW is also accepted.
- Arbitration: buttons have fixed priority over I2C.
  - An I2C start in the same cycle as a button roll start, or during BTN_ROLL/I2C_ROLL, is dropped and sets collision.
  - An I2C start with die code 7 is dropped without setting collision.
- Register map (I2C write = i2c_wen; takes effect next cycle):
  - 0x00 CTRL: write bit7=1 requests a start with die bits[2:0]; bit7 reads 0. Read returns {1'b0,4'b0,die}.
  - 0x01 STATUS: read {busy,display_en,src,collision,1'b0,die}. An i2c_rdata_used pulse while addr=0x01 clears collision. A collision set in the same cycle wins.
  - 0x02 RESULT: read {digit10,digit1}.
  - 0x03 TIMEOUT: read/write. A new value applies at the next SHOW entry.
  - 0x04 ROLL_LEN: read/write. A new value applies at the next I2C roll.
  - Other addresses read 0x00; writes to them are ignored.
- Reset mid-roll: the block returns to reset values immediately, with no display flash.

Test Plan:
- Reset: after rst pulse, RESULT=0x01, STATUS=0x00, TIMEOUT=0xFF, ROLL_LEN=0x10, display_en=0.
- Hold btn[0] 13 clks then release -> values step 04,03,02,01,04,... and the result freezes at the value of the last busy cycle. display_en rises the cycle after release and falls after 255 ticks.
- Write TIMEOUT=2, ROLL_LEN=3, then CTRL=0x86 -> busy for 3 ticks, src=1, die=6, result in 00..99, display_en high for exactly 2 ticks.
- Write CTRL=0x85 during BTN_ROLL and again in the same cycle btn[3] rises from IDLE -> both dropped, collision=1. Reading STATUS with rdata_used clears it.
- btn[2] and btn[5] pressed together -> die=2 and values stay within 1..8. Releasing btn[5] only keeps rolling.
- CTRL=0x87 -> no state change, collision stays 0. Assert rst during I2C_ROLL -> all outputs at reset values on the same edge.

Source files
------------

// File: rtl/dice_roll_ctrl.sv
// Dice-roll sequencer: arbitrates between the seven die buttons and the
// I2C application interface, runs the rolling BCD counter, times the roll
// (I2C) and the result display, and exposes a small register map.
module dice_roll_ctrl #(
  parameter logic [7:0] TIMEOUT_DEFAULT  = 8'd255,
  parameter logic [7:0] ROLL_LEN_DEFAULT = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] btn,
  input  logic       i2c_wen,
  input  logic [7:0] i2c_addr,
  input  logic [7:0] i2c_wdata,
  input  logic       i2c_rdata_used,
  output logic [7:0] i2c_rdata,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic       display_en,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BTN_ROLL, I2C_ROLL, SHOW} state_t;

  state_t     state, state_nxt;
  logic [2:0] die, die_nxt;
  logic       src, src_nxt;
  logic       collision;
  logic [7:0] value, value_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] timeout_r;
  logic [7:0] roll_len_r;

  // Largest face of each die, as two BCD digits.
  function automatic logic [7:0] die_max(input logic [2:0] d);
    case (d)
      3'd0:    die_max = 8'h04;
      3'd1:    die_max = 8'h06;
      3'd2:    die_max = 8'h08;
      3'd3:    die_max = 8'h10;
      3'd4:    die_max = 8'h12;
      3'd5:    die_max = 8'h20;
      3'd6:    die_max = 8'h99;
      default: die_max = 8'h01;
    endcase
  endfunction

  // Smallest face: the percentile die starts at 00, all others at 01.
  function automatic logic [7:0] die_min(input logic [2:0] d);
    die_min = (d == 3'd6) ? 8'h00 : 8'h01;
  endfunction

  // One rolling step: BCD decrement, wrapping from min back to max.
  function automatic logic [7:0] roll_step(input logic [7:0] v, input logic [2:0] d);
    if (v == die_min(d))
      roll_step = die_max(d);
    else if (v[3:0] == 4'd0)
      roll_step = {v[7:4] - 4'd1, 4'd9};
    else
      roll_step = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Lowest-index pressed button selects the die.
  function automatic logic [2:0] first_set(input logic [6:0] b);
    first_set = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (b[i]) first_set = i[2:0];
  endfunction

  logic btn_any, idle_like, wr_ctrl, i2c_start, i2c_accept, i2c_collide;

  assign btn_any     = |btn;
  assign idle_like   = (state == IDLE) || (state == SHOW);
  assign wr_ctrl     = i2c_wen && (i2c_addr == 8'h00);
  // Die code 7 is not a die; such a request is silently discarded.
  assign i2c_start   = wr_ctrl && i2c_wdata[7] && (i2c_wdata[2:0] != 3'd7);
  // Buttons always win: an I2C start only lands when no button is pressed.
  assign i2c_accept  = i2c_start && idle_like && !btn_any;
  assign i2c_collide = i2c_start && !i2c_accept;

  assign busy       = (state == BTN_ROLL) || (state == I2C_ROLL);
  assign display_en = (state == SHOW);
  assign digit10    = value[7:4];
  assign digit1     = value[3:0];

  // Next-state, rolling value and tick counter.
  always_comb begin
    state_nxt = state;
    die_nxt   = die;
    src_nxt   = src;
    value_nxt = value;
    cnt_nxt   = cnt;
    case (state)
      IDLE, SHOW: begin
        if (btn_any) begin
          state_nxt = BTN_ROLL;
          die_nxt   = first_set(btn);
          src_nxt   = 1'b0;
          value_nxt = die_max(first_set(btn));
        end else if (i2c_accept) begin
          state_nxt = I2C_ROLL;
          die_nxt   = i2c_wdata[2:0];
          src_nxt   = 1'b1;
          cnt_nxt   = roll_len_r;
          value_nxt = die_max(i2c_wdata[2:0]);
        end else if (state == SHOW && tick) begin
          if (cnt <= 8'd1) state_nxt = IDLE;
          else             cnt_nxt   = cnt - 8'd1;
        end
      end
      BTN_ROLL: begin
        if (btn[die]) begin
          value_nxt = roll_step(value, die);
        end else begin
          state_nxt = SHOW;
          cnt_nxt   = timeout_r;
        end
      end
      I2C_ROLL: begin
        if (tick && cnt <= 8'd1) begin
          state_nxt = SHOW;
          cnt_nxt   = timeout_r;
        end else begin
          value_nxt = roll_step(value, die);
          if (tick) cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, die/source latch, value and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      die   <= 3'd0;
      src   <= 1'b0;
      value <= 8'h01;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      die   <= die_nxt;
      src   <= src_nxt;
      value <= value_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sticky collision flag; a new collision beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      collision <= 1'b0;
    else if (i2c_collide)
      collision <= 1'b1;
    else if (i2c_rdata_used && i2c_addr == 8'h01)
      collision <= 1'b0;
  end

  // Host-writable timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r  <= TIMEOUT_DEFAULT;
      roll_len_r <= ROLL_LEN_DEFAULT;
    end else if (i2c_wen) begin
      if (i2c_addr == 8'h03) timeout_r  <= i2c_wdata;
      if (i2c_addr == 8'h04) roll_len_r <= i2c_wdata;
    end
  end

  // Register read mux.
  always_comb begin
    i2c_rdata = 8'h00;
    case (i2c_addr)
      8'h00:   i2c_rdata = {5'b0, die};
      8'h01:   i2c_rdata = {busy, display_en, src, collision, 1'b0, die};
      8'h02:   i2c_rdata = value;
      8'h03:   i2c_rdata = timeout_r;
      8'h04:   i2c_rdata = roll_len_r;
      default: i2c_rdata = 8'h00;
    endcase
  end

endmodule
